// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, threshold flags, sticky
// overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  unused_ptr_msb;

    // Flags come from the registered count, so an empty->non-empty transition
    // becomes visible exactly one cycle after the write edge.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_TH));
    assign almost_empty = (count <= CW'(AEMPTY_TH));

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Occupancy is tracked by count; pointer MSBs only keep the wrap modulo 2*DEPTH.
    assign unused_ptr_msb = wptr[AW] ^ rptr[AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A same-cycle error condition wins over err_clr.
            overflow  <= (overflow  && !err_clr) || (wr_en && full);
            underflow <= (underflow && !err_clr) || (rd_en && empty);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wptr[AW-1:0]] <= wdata;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (rst)        rdata_q <= '0;
                else if (rd_ok) rdata_q <= mem[rptr[AW-1:0]];
            end
            assign rdata = rdata_q;
        end else begin : g_fwft
            // Head entry is always on the port; rd_en just acknowledges it.
            assign rdata = mem[rptr[AW-1:0]];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-read instance and an FWFT instance,
// each step checked with immediate assertions against hand-computed values.
module tb_sync_fifo;
    logic       clk;
    logic       rst;
    logic       wr_en, rd_en, err_clr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_wr_en, f_rd_en, f_err_clr;
    logic [7:0] f_wdata;
    logic [7:0] f_rdata;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en),
        .rdata(f_rdata), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .err_clr(f_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wdata = 8'h00;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_wdata = 8'h00;
        step();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_f_empty", 32'(f_empty), 1);

        // Fill 0x01..0x10, then drain in order.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wdata = 8'(i + 1);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
            check("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
        end
        wr_en = 1'b0;
        check("fill_full", 32'(full), 1);
        check("fill_not_empty", 32'(empty), 0);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            step();
            check("drain_rdata", 32'(rdata), 32'(i + 1));
            check("drain_count", 32'(count), 32'(15 - i));
        end
        rd_en = 1'b0;
        step();
        check("drain_empty", 32'(empty), 1);
        check("drain_hold_rdata", 32'(rdata), 32'h10);

        // Overflow while full; read+write while full does the read only.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wdata = 8'(i + 1);
            step();
        end
        wdata = 8'hAA;
        step();
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        rd_en = 1'b1; wdata = 8'hCC;
        step();
        check("full_rw_rdata", 32'(rdata), 32'h01);
        check("full_rw_count", 32'(count), 15);
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b1;
        step();
        check("ovf_clr", 32'(overflow), 0);
        wr_en = 1'b1; wdata = 8'h11;
        step();
        check("clr_write_count", 32'(count), 16);
        check("clr_write_ovf", 32'(overflow), 0);
        step();
        check("ovf_set_beats_clr", 32'(overflow), 1);
        wr_en = 1'b0;
        step();
        check("ovf_clr2", 32'(overflow), 0);
        err_clr = 1'b0; rd_en = 1'b1;
        step();
        check("head_after_ovf", 32'(rdata), 32'h02);
        rd_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_count", 32'(count), 0);

        // Underflow, then read+write on empty does the write only.
        rd_en = 1'b1;
        step();
        check("unf_set", 32'(underflow), 1);
        check("unf_count", 32'(count), 0);
        check("unf_rdata_hold", 32'(rdata), 0);
        wr_en = 1'b1; wdata = 8'h55;
        step();
        check("empty_rw_count", 32'(count), 1);
        check("empty_rw_rdata", 32'(rdata), 0);
        wr_en = 1'b0;
        step();
        check("rd_55", 32'(rdata), 32'h55);
        check("rd_55_empty", 32'(empty), 1);
        rd_en = 1'b0; err_clr = 1'b1;
        step();
        check("unf_clr", 32'(underflow), 0);
        err_clr = 1'b0;

        // Steady state at count 8 across pointer wraps.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wdata = 8'(8'h20 + i);
            step();
        end
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wdata = 8'(8'h28 + i);
            step();
            check("stream_rdata", 32'(rdata), 32'(8'h20 + i));
            check("stream_count", 32'(count), 8);
        end
        check("stream_afull", 32'(almost_full), 0);
        check("stream_aempty", 32'(almost_empty), 0);

        // Reach count 10 with overflow set, then reset with a write pending.
        rd_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wdata = 8'(8'h60 + i);
            step();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        rd_en = 1'b0;
        check("pre_rst_count", 32'(count), 10);
        check("pre_rst_ovf", 32'(overflow), 1);
        rst = 1'b1; wr_en = 1'b1; wdata = 8'hEE;
        step();
        rst = 1'b0; wr_en = 1'b0;
        check("rst3_count", 32'(count), 0);
        check("rst3_empty", 32'(empty), 1);
        check("rst3_aempty", 32'(almost_empty), 1);
        check("rst3_ovf", 32'(overflow), 0);
        wr_en = 1'b1; wdata = 8'h77;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("post_rst_rdata", 32'(rdata), 32'h77);

        // FWFT: head appears one cycle after the write without rd_en.
        f_wr_en = 1'b1; f_wdata = 8'h3C;
        step();
        f_wr_en = 1'b0;
        check("fwft_empty", 32'(f_empty), 0);
        check("fwft_rdata", 32'(f_rdata), 32'h3C);
        step();
        check("fwft_hold", 32'(f_rdata), 32'h3C);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fwft_pop_empty", 32'(f_empty), 1);
        f_wr_en = 1'b1; f_wdata = 8'h4D;
        step();
        f_wdata = 8'h5E;
        step();
        f_wr_en = 1'b0;
        check("fwft_head2", 32'(f_rdata), 32'h4D);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fwft_head3", 32'(f_rdata), 32'h5E);
        check("fwft_count", 32'(f_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; legal values are powers of two >= 4.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have parameter FWFT, default 0; 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  read data.
REQ-012 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow, underflow  output  1 each  sticky error flags.
REQ-015 SHALL have port err_clr  input  1  clears the sticky error flags.

Function
REQ-016 Write SHALL be accepted iff wr_en=1 and full=0; wdata is stored at wptr and wptr increments.
REQ-017 Read SHALL be accepted iff rd_en=1 and empty=0; rptr increments.
REQ-018 Pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
REQ-019 count SHALL update as follows: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither; it SHALL be registered.
REQ-020 Simultaneous wr_en and rd_en when full=1 SHALL perform only the read; the write is rejected and sets overflow.
REQ-021 Simultaneous wr_en and rd_en when empty=1 SHALL perform only the write; the read is rejected and sets underflow.
REQ-022 Flags SHALL be derived from count: full=(count==DEPTH); empty=(count==0); almost_full=(count>=AFULL_TH); almost_empty=(count<=AEMPTY_TH).
REQ-023 With FWFT=0, rdata SHALL be registered and present the popped word one cycle after the accepted read; otherwise it holds its last value.
REQ-024 With FWFT=1, rdata SHALL equal the head entry whenever empty=0, the same cycle it becomes visible; rd_en acknowledges and pops it; rdata is don't-care while empty=1.
REQ-025 A word written into an empty FIFO SHALL cause empty to deassert on the cycle after the write edge (write-to-read latency 1 cycle, both modes).
REQ-026 overflow SHALL set on any cycle with wr_en=1 and full=1; underflow SHALL set on rd_en=1 and empty=1; both hold until cleared.
REQ-027 err_clr=1 SHALL clear overflow and underflow next edge; a same-cycle set condition SHALL take priority over the clear.
REQ-028 Rejected operations SHALL NOT modify memory, pointers or count.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rdata=0.
REQ-030 Reset SHALL take priority over wr_en, rd_en and err_clr in the same cycle; memory contents are not cleared, but all stored data is discarded.
REQ-031 Reset asserted mid-operation (any count) SHALL return the block to the REQ-029 state on the next edge; the first write after reset lands at address 0.

Verification
REQ-032 Defaults, FWFT=0: write 0x01..0x10 (16 words) then read 16 -> full=1 after the 16th write, rdata sequence 0x01..0x10 each one cycle after rd_en, empty=1 at the end.
REQ-033 Fill to 16, then one more write of 0xAA -> overflow=1, count stays 16, the first read returns 0x01; pulse err_clr -> overflow=0.
REQ-034 Empty FIFO, rd_en=1 -> underflow=1, count=0, rdata unchanged; simultaneous wr_en with wdata=0x55 -> count=1, next read returns 0x55.
REQ-035 count=8, continuous wr_en+rd_en for 40 cycles (pointers wrap twice) -> count stays 8, data order preserved, almost_full=0, almost_empty=0.
REQ-036 FWFT=1: write 0x3C into empty FIFO -> next cycle empty=0 and rdata=0x3C with no rd_en; rd_en -> empty=1 next cycle.
REQ-037 count=10 with overflow=1, assert rst one cycle -> count=0, empty=1, almost_empty=1, overflow=0; subsequent write/read of 0x77 returns 0x77.
